kbitsubtractor_pipe: RTL and testbench
======================================

KBITSUBTRACTOR_PIPE -- requirements
Module: kbitsubtractor_pipe

Interface
REQ-001 SHALL have parameter n, default 8, giving the operand width; n SHALL be even and >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port A, input, n, the minuend, unsigned or two's complement.
REQ-005 SHALL have port B, input, n, the subtrahend.
REQ-006 SHALL have port in_valid, input, 1: A/B carry a request this cycle.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a request this cycle.
REQ-008 SHALL have port diff, output, n: the result A-B mod 2^n.
REQ-009 SHALL have port bout, output, 1: borrow out, 1 iff unsigned A < B.
REQ-010 SHALL have port ovf, output, 1: two's-complement overflow of A-B.
REQ-011 SHALL have port out_valid, output, 1: diff/bout/ovf hold a result.
REQ-012 SHALL have port out_ready, input, 1: the downstream consumer accepts the result.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1 (input transfer); otherwise it SHALL ignore A/B.
REQ-014 SHALL deliver a result on a rising edge where out_valid=1 and out_ready=1 (output transfer).
REQ-015 SHALL compute the difference as A + ~B + 1 using a carry-select structure: the low half takes carry-in 1; the upper half is evaluated for carry-in 0 and carry-in 1.
REQ-016 Stage 1 SHALL register the low-half difference, the low-half carry, both upper-half candidate differences, both candidate carries, A[n-1] and B[n-1], and a stage-1 valid bit.
REQ-017 Stage 2 SHALL use the registered low-half carry to select the upper-half candidate and its carry.
REQ-018 Stage 2 SHALL register diff, set bout = NOT(selected carry), set ovf = (A[n-1] != B[n-1]) AND (diff[n-1] != A[n-1]), and set out_valid.
REQ-019 Latency: a request transferred on edge N SHALL appear with out_valid=1 after edge N+1, i.e. two edges, with no stalls.
REQ-020 Throughput SHALL be one result per cycle while out_ready=1.
REQ-021 Stage 2 SHALL be able to load when out_valid=0 or out_ready=1 (s2_free).
REQ-022 in_ready SHALL equal (stage-1 valid = 0) OR s2_free, derived combinationally.
REQ-023 Stall: while out_valid=1 and out_ready=0, diff, bout, ovf and out_valid SHALL hold unchanged.
REQ-024 Stall: while out_valid=1 and out_ready=0, stage 1 SHALL hold its contents if valid, and SHALL still accept one request if empty.
REQ-025 Simultaneous transfers: an output transfer and a stage-1 to stage-2 move on the same edge SHALL replace the output with the new result, and no result SHALL be lost or duplicated.
REQ-026 Simultaneous transfers: an input transfer and a stage-1 to stage-2 move on the same edge SHALL load stage 1 with the new request.
REQ-027 Drain: when stage 1 is empty and an output transfer occurs, out_valid SHALL fall to 0 on that edge.
REQ-028 Results SHALL leave in the order requests were accepted.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL clear out_valid, the stage-1 valid bit, diff, bout and ovf to 0.
REQ-030 Reset SHALL override any transfer on the same edge, and SHALL discard any in-flight requests with no result emitted.
REQ-031 in_ready SHALL read 1 in the cycle after reset.
REQ-032 Stage-1 data registers need not be cleared by reset.

Verification (n=8)
REQ-033 A=0x05, B=0x03, out_ready=1 -> two edges later diff=0x02, bout=0, ovf=0, out_valid=1 for one cycle.
REQ-034 A=0x03, B=0x05 -> diff=0xFE, bout=1, ovf=0.
REQ-035 A=0x80, B=0x01 -> diff=0x7F, bout=0, ovf=1; then A=0x7F, B=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-036 Stream 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepted and first result held stable; then out_ready=1 -> all 4 results emerge in order on consecutive cycles.
REQ-037 Accept A=0x10, B=0x01, then assert rst on the next edge -> out_valid stays 0, in_ready=1, no 0x0F result ever appears.
REQ-038 Random self-check: 10k random A/B values with random in_valid/out_ready -> every result matches (A-B) mod 256, A<B for bout, and the signed-overflow rule for ovf, in order.

Source files
------------

// File: rtl/kbitsubtractor_pipe.sv
// Two-stage pipelined n-bit subtractor (A - B) built as a carry-select adder
// on A + ~B + 1, with valid/ready flow control on both sides.
module kbitsubtractor_pipe #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int H = n / 2;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; a producer holds its payload and valid until that edge.

    logic [H:0]   lo_sum;
    logic [H:0]   hi_sum0;
    logic [H:0]   hi_sum1;

    logic         s1_valid;
    logic [H-1:0] s1_lo;
    logic         s1_c_lo;
    logic [H-1:0] s1_hi0;
    logic [H-1:0] s1_hi1;
    logic         s1_c0;
    logic         s1_c1;
    logic         s1_a_msb;
    logic         s1_b_msb;

    logic         s2_free;
    logic         s1_load;
    logic         s1_move;
    logic [H-1:0] sel_hi;
    logic         sel_c;

    always_comb begin
        lo_sum  = {1'b0, A[H-1:0]} + {1'b0, ~B[H-1:0]} + {{H{1'b0}}, 1'b1};
        hi_sum0 = {1'b0, A[n-1:H]} + {1'b0, ~B[n-1:H]};
        hi_sum1 = {1'b0, A[n-1:H]} + {1'b0, ~B[n-1:H]} + {{H{1'b0}}, 1'b1};
    end

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign s1_load  = in_valid && in_ready;
    assign s1_move  = s1_valid && s2_free;

    // Low-half carry picks the precomputed upper half and its carry.
    assign sel_hi = s1_c_lo ? s1_hi1 : s1_hi0;
    assign sel_c  = s1_c_lo ? s1_c1  : s1_c0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage-1 payload carries no reset; it is qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_lo    <= lo_sum[H-1:0];
            s1_c_lo  <= lo_sum[H];
            s1_hi0   <= hi_sum0[H-1:0];
            s1_hi1   <= hi_sum1[H-1:0];
            s1_c0    <= hi_sum0[H];
            s1_c1    <= hi_sum1[H];
            s1_a_msb <= A[n-1];
            s1_b_msb <= B[n-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= {sel_hi, s1_lo};
                bout <= !sel_c;
                ovf  <= (s1_a_msb != s1_b_msb) && (sel_hi[H-1] != s1_a_msb);
            end
        end
    end

endmodule

// File: tb/tb_kbitsubtractor_pipe.sv
// Self-checking bench for kbitsubtractor_pipe (n=8): directed vectors with
// hand-computed results, then a randomized run against a scoreboard queue.
module tb_kbitsubtractor_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    kbitsubtractor_pipe #(.n(8)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .diff(diff), .bout(bout), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        int sd;
        logic [7:0] d;
        logic o;
        sd = int'($signed(x)) - int'($signed(y));
        d  = 8'(int'(x) - int'(y));
        o  = (sd > 127) || (sd < -128);
        return {(int'(x) < int'(y)) ? 1'b1 : 1'b0, o, d};
    endfunction

    task automatic check_out(input string tag, input logic [7:0] d, input logic bo, input logic ov);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {22'd0, bout, ovf, diff}, {22'd0, bo, ov, d});
    endtask

    task automatic run_one(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] d, input logic bo, input logic ov);
        out_ready = 1'b1;
        a = x; b = y; in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check_out(tag, d, bo, ov);
        tick();
        check({tag, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        int accepted;
        int cycles;
        logic [9:0] e;

        rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_res", {22'd0, bout, ovf, diff}, 32'd0);

        run_one("v05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_one("v03m05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_one("v80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_one("v7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Backpressure: two accepted, then stall with first result held.
        sa = '{8'h10, 8'h20, 8'h80, 8'h00};
        sb = '{8'h01, 8'h30, 8'h01, 8'h01};
        out_ready = 1'b0;
        in_valid = 1'b1; a = sa[0]; b = sb[0];
        tick();
        a = sa[1]; b = sb[1];
        check("stall_acc1", {31'd0, in_ready}, 32'd1);
        tick();
        a = sa[2]; b = sb[2];
        check("stall_ready_low", {31'd0, in_ready}, 32'd0);
        check_out("stall_r0", 8'h0F, 1'b0, 1'b0);
        tick(); tick();
        check("stall_ready_low2", {31'd0, in_ready}, 32'd0);
        check_out("stall_hold", 8'h0F, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("unstall_ready", {31'd0, in_ready}, 32'd1);
        tick();
        a = sa[3]; b = sb[3];
        check_out("stream_r1", 8'hF0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_out("stream_r2", 8'h7F, 1'b0, 1'b1);
        tick();
        check_out("stream_r3", 8'hFF, 1'b1, 1'b0);
        tick();
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Reset discards an in-flight request.
        a = 8'h10; b = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_result", {31'd0, out_valid}, 32'd0);
        end

        // Randomized stream against the scoreboard.
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_res", {22'd0, bout, ovf, diff}, {22'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                accepted++;
            end
            cycles++;
            tick();
        end
        check("rand_budget", accepted, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                check("drain_res", {22'd0, bout, ovf, diff}, {22'd0, e});
            end
            cycles++;
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
        #1;
        check("drain_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
